// File: rtl/seq_divider_nb.sv
// seq_divider_nb: multi-cycle unsigned divider, Q = A / B and R = A mod B.
// It runs one restoring-division step per clock, using a single (D+1)-bit
// subtract done as P' + ~B + 1. It works as a start/done coprocessor.
//
// Ports:
//   i_clk        clock; all state updates on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_start      division request; sampled only while o_ready = 1
//   i_dividend   operand A, captured when a start is accepted
//   i_divisor    operand B, captured when a start is accepted
//   o_ready      idle; a start can be accepted
//   o_done       one-cycle pulse; the result registers are valid
//   o_quotient   quotient (registered)
//   o_remainder  remainder (registered)
//   o_div_zero   the last accepted operation had divisor = 0
//
// state | meaning
// IDLE  | waiting for i_start; o_ready = 1
// CALC  | one restoring step per cycle, D steps in total
// DONE  | results valid; o_done = 1 for this single cycle
module seq_divider_nb #(
  parameter int D = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [D-1:0] i_dividend,
  input  logic [D-1:0] i_divisor,
  output logic         o_ready,
  output logic         o_done,
  output logic [D-1:0] o_quotient,
  output logic [D-1:0] o_remainder,
  output logic         o_div_zero
);

  localparam int CW = (D > 2) ? $clog2(D) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(D - 1);
  localparam logic [D:0]    ONE      = {{D{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t state, state_nxt;

  // The top bit of the partial remainder is always 0 after a step, because
  // the stored value is always < B. Only the low D bits are kept.
  logic [D-1:0]  p_reg;
  logic [D-1:0]  q_reg;
  logic [D-1:0]  b_reg;
  logic [CW-1:0] cnt;

  logic [D:0]    p_sh;
  logic [D:0]    t_sub;
  logic [D-1:0]  p_nxt;
  logic [D-1:0]  q_nxt;
  logic          last_step;
  logic          div_by_zero;

  assign last_step   = (cnt == CNT_LAST);
  assign div_by_zero = (i_divisor == '0);

  // One restoring step. A clear borrow bit (t_sub[D] = 0) means P' >= B.
  always_comb begin
    p_sh  = {p_reg, q_reg[D-1]};
    t_sub = p_sh + ~{1'b0, b_reg} + ONE;
    p_nxt = t_sub[D] ? p_sh[D-1:0] : t_sub[D-1:0];
    q_nxt = {q_reg[D-2:0], ~t_sub[D]};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_done    = 1'b0;
    case (state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_start) state_nxt = div_by_zero ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (last_step) state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p_reg       <= '0;
      q_reg       <= '0;
      b_reg       <= '0;
      cnt         <= '0;
      o_quotient  <= '0;
      o_remainder <= '0;
      o_div_zero  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            if (div_by_zero) begin
              // Skip CALC entirely and publish the divide-by-zero result.
              o_quotient  <= '1;
              o_remainder <= i_dividend;
              o_div_zero  <= 1'b1;
            end else begin
              b_reg      <= i_divisor;
              p_reg      <= '0;
              q_reg      <= i_dividend;
              cnt        <= '0;
              o_div_zero <= 1'b0;
            end
          end
        end
        S_CALC: begin
          p_reg <= p_nxt;
          q_reg <= q_nxt;
          cnt   <= cnt + 1'b1;
          if (last_step) begin
            o_quotient  <= q_nxt;
            o_remainder <= p_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_nb.sv
// tb_seq_divider_nb: self-checking bench for seq_divider_nb (D = 16).
// A timeline model predicts ready/done/results from plain / and % arithmetic.
// It is checked against the DUT after every clock edge. Directed cases pin
// literal results, and a random sweep checks A = Q*B + R with R < B.
module tb_seq_divider_nb;
  localparam int D = 16;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic [D-1:0] i_dividend = '0;
  logic [D-1:0] i_divisor = '0;
  logic         o_ready;
  logic         o_done;
  logic [D-1:0] o_quotient;
  logic [D-1:0] o_remainder;
  logic         o_div_zero;

  seq_divider_nb #(.D(D)) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_start(i_start),
    .i_dividend(i_dividend),
    .i_divisor(i_divisor),
    .o_ready(o_ready),
    .o_done(o_done),
    .o_quotient(o_quotient),
    .o_remainder(o_remainder),
    .o_div_zero(o_div_zero)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an accepted start schedules a result D edges later
  // (or immediately when B = 0). The done cycle lasts one edge, then the
  // block is ready again.
  logic         m_ready, m_done, m_dz;
  logic [D-1:0] m_q, m_r, pend_q, pend_r;
  int           m_wait;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_ready = 1'b1; m_done = 1'b0; m_dz = 1'b0;
      m_q = '0; m_r = '0; m_wait = 0;
    end else if (m_done) begin
      m_done  = 1'b0;
      m_ready = 1'b1;
    end else if (m_ready) begin
      if (i_start) begin
        m_ready = 1'b0;
        if (i_divisor == '0) begin
          m_q = '1; m_r = i_dividend; m_dz = 1'b1; m_done = 1'b1;
        end else begin
          pend_q = i_dividend / i_divisor;
          pend_r = i_dividend % i_divisor;
          m_dz   = 1'b0;
          m_wait = D;
        end
      end
    end else begin
      m_wait--;
      if (m_wait == 0) begin
        m_q = pend_q; m_r = pend_r; m_done = 1'b1;
      end
    end
  end

  always @(posedge i_clk) begin
    #1;
    chk("model_ready", 32'(o_ready), 32'(m_ready));
    chk("model_done", 32'(o_done), 32'(m_done));
    chk("model_quotient", 32'(o_quotient), 32'(m_q));
    chk("model_remainder", 32'(o_remainder), 32'(m_r));
    chk("model_div_zero", 32'(o_div_zero), 32'(m_dz));
  end

  task automatic wait_ready();
    int k;
    k = 0;
    @(negedge i_clk);
    while (!o_ready && k < 50) begin
      @(negedge i_clk);
      k++;
    end
    chk("ready_before_start", 32'(o_ready), 32'd1);
  endtask

  task automatic do_op(input logic [D-1:0] a, input logic [D-1:0] b, input bit lit,
                       input logic [D-1:0] eq, input logic [D-1:0] er, input logic edz);
    int k, rl;
    bit seen;
    int unsigned qq, rr;
    wait_ready();
    i_dividend = a; i_divisor = b; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_dividend = 16'($urandom);
    i_divisor  = 16'($urandom);
    k = 0;
    rl = o_ready ? 0 : 1;
    seen = o_done;
    while (!seen && k < 40) begin
      @(posedge i_clk); #1;
      k++;
      if (!o_ready) rl++;
      seen = o_done;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("done_latency", 32'(k), (b == '0) ? 32'd0 : 32'(D));
    qq = o_quotient; rr = o_remainder;
    if (b != '0) begin
      chk("identity_a_eq_qb_plus_r", qq * b + rr, 32'(a));
      chk("remainder_lt_divisor", 32'(rr < b), 32'd1);
    end
    if (lit) begin
      chk("lit_quotient", qq, 32'(eq));
      chk("lit_remainder", rr, 32'(er));
      chk("lit_div_zero", 32'(o_div_zero), 32'(edz));
    end
    @(posedge i_clk); #1;
    chk("done_single_cycle", 32'(o_done), 32'd0);
    chk("ready_low_cycles", 32'(rl), (b == '0) ? 32'd1 : 32'(D + 1));
    chk("ready_after_done", 32'(o_ready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    logic [D-1:0] ra, rb;
    #2;
    chk("reset_ready", 32'(o_ready), 32'd1);
    chk("reset_done", 32'(o_done), 32'd0);
    chk("reset_quotient", 32'(o_quotient), 32'd0);
    chk("reset_remainder", 32'(o_remainder), 32'd0);
    chk("reset_div_zero", 32'(o_div_zero), 32'd0);
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;

    do_op(16'd100, 16'd7, 1'b1, 16'd14, 16'd2, 1'b0);
    do_op(16'hFFFF, 16'd1, 1'b1, 16'hFFFF, 16'd0, 1'b0);
    do_op(16'd3, 16'd10, 1'b1, 16'd0, 16'd3, 1'b0);
    do_op(16'h8000, 16'hFFFF, 1'b1, 16'd0, 16'h8000, 1'b0);
    do_op(16'd5, 16'd0, 1'b1, 16'hFFFF, 16'd5, 1'b1);
    do_op(16'd9, 16'd3, 1'b1, 16'd3, 16'd0, 1'b0);

    // Starts pulsed during CALC are ignored.
    wait_ready();
    i_dividend = 16'd100; i_divisor = 16'd7; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    dones = 0;
    for (int e = 1; e <= 22; e++) begin
      if (e == 3 || e == 16) begin
        @(negedge i_clk);
        i_dividend = 16'd50; i_divisor = 16'd5; i_start = 1'b1;
      end
      @(posedge i_clk); #1;
      i_start = 1'b0;
      if (o_done) begin
        dones++;
        chk("ignored_done_edge", 32'(e), 32'd16);
        chk("ignored_quotient", 32'(o_quotient), 32'd14);
        chk("ignored_remainder", 32'(o_remainder), 32'd2);
      end
    end
    chk("ignored_done_count", 32'(dones), 32'd1);

    // Reset asserted mid-CALC.
    wait_ready();
    i_dividend = 16'd1000; i_divisor = 16'd3; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (8) begin
      @(posedge i_clk); #1;
    end
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("midreset_ready", 32'(o_ready), 32'd1);
    chk("midreset_done", 32'(o_done), 32'd0);
    chk("midreset_quotient", 32'(o_quotient), 32'd0);
    chk("midreset_remainder", 32'(o_remainder), 32'd0);
    chk("midreset_div_zero", 32'(o_div_zero), 32'd0);
    dones = 0;
    repeat (12) begin
      @(posedge i_clk); #1;
      if (o_done) dones++;
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (10) begin
      @(posedge i_clk); #1;
      if (o_done) dones++;
    end
    chk("midreset_no_done", 32'(dones), 32'd0);
    do_op(16'd1000, 16'd3, 1'b1, 16'd333, 16'd1, 1'b0);

    // Random sweep; divisor size is mixed so quotients span the full range.
    for (int n = 0; n < 2500; n++) begin
      case ($urandom_range(0, 4))
        0: ra = 16'hFFFF;
        1: ra = 16'($urandom_range(0, 255));
        default: ra = 16'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: rb = 16'($urandom_range(1, 15));
        1: rb = 16'($urandom_range(1, 255));
        2: rb = 16'($urandom_range(1, 65535));
        default: rb = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      endcase
      do_op(ra, rb, 1'b0, '0, '0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
